// File: rtl/gcd_pkg.sv
// Shared definitions for the GCD front-end: feeder FSM state encoding and default datapath width.
package gcd_pkg;

    localparam int GCD_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

endpackage

// File: rtl/gcd_pair_fifo.sv
// Operand-pair FIFO: power-of-two depth, wrapping pointers, occupancy count with one extra bit.
module gcd_pair_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         push_a,
    input  logic [WIDTH-1:0]         push_b,
    output logic [WIDTH-1:0]         head_a,
    output logic [WIDTH-1:0]         head_b,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [2*WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]      wr_ptr_reg;
    logic [PW-1:0]      rd_ptr_reg;
    logic [CW-1:0]      count_reg;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= {push_a, push_b};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Head is read combinationally; the feeder's operand registers capture it at the pop edge.
    assign {head_a, head_b} = mem[rd_ptr_reg];
    assign count = count_reg;
    assign full  = (count_reg == CW'(DEPTH));
    assign empty = (count_reg == '0);

endmodule

// File: rtl/gcd_operand_feeder.sv
// Buffers operand pairs and issues them one at a time to the GCD core with a watchdog.
// Define GCD_FEEDER_SWAP_EN to present the larger operand on core_a at load time.
module gcd_operand_feeder
    import gcd_pkg::*;
#(
    parameter int WIDTH   = GCD_WIDTH,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_a,
    input  logic [WIDTH-1:0]       in_b,
    output logic                   core_start,
    output logic [WIDTH-1:0]       core_a,
    output logic [WIDTH-1:0]       core_b,
    input  logic                   core_done,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] count,
    output logic                   timeout_err
);

    localparam int WDW = $clog2(TIMEOUT);

    state_t           state_reg;
    state_t           state_next;
    logic [WDW-1:0]   wd_reg;
    logic [WIDTH-1:0] core_a_reg;
    logic [WIDTH-1:0] core_b_reg;
    logic [WIDTH-1:0] head_a;
    logic [WIDTH-1:0] head_b;
    logic [WIDTH-1:0] load_a;
    logic [WIDTH-1:0] load_b;
    logic             fifo_full;
    logic             fifo_empty;
    logic             push;
    logic             pop;
    logic             timeout_hit;
    logic             wd_expired;

    assign in_ready = !fifo_full && !rst;
    assign push     = in_valid && in_ready;

    gcd_pair_fifo #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .push   (push),
        .pop    (pop),
        .push_a (in_a),
        .push_b (in_b),
        .head_a (head_a),
        .head_b (head_b),
        .count  (count),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

`ifdef GCD_FEEDER_SWAP_EN
    assign load_a = (head_a < head_b) ? head_b : head_a;
    assign load_b = (head_a < head_b) ? head_a : head_b;
`else
    assign load_a = head_a;
    assign load_b = head_b;
`endif

    assign wd_expired = (wd_reg == WDW'(TIMEOUT - 1));

    always_comb begin
        state_next  = state_reg;
        pop         = 1'b0;
        timeout_hit = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: state_next = WAIT;
            WAIT: begin
                // A done arriving on the expiry cycle takes priority over the watchdog.
                if (core_done) begin
                    state_next = IDLE;
                end else if (wd_expired) begin
                    timeout_hit = 1'b1;
                    state_next  = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            wd_reg     <= '0;
            core_a_reg <= '0;
            core_b_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == ISSUE) begin
                wd_reg <= '0;
            end else if (state_reg == WAIT) begin
                wd_reg <= wd_reg + WDW'(1);
            end
            if (pop) begin
                core_a_reg <= load_a;
                core_b_reg <= load_b;
            end
        end
    end

    assign core_start  = (state_reg == ISSUE) && !rst;
    assign timeout_err = timeout_hit && !rst;
    assign busy        = (state_reg != IDLE);
    assign core_a      = core_a_reg;
    assign core_b      = core_b_reg;

endmodule

// File: tb/tb_gcd_operand_feeder.sv
// Scoreboard bench for gcd_operand_feeder: queued expected pairs, issue timing, occupancy and watchdog.
module tb_gcd_operand_feeder;

    localparam int W  = 8;
    localparam int D  = 4;
    localparam int TO = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic [W-1:0] in_a = '0;
    logic [W-1:0] in_b = '0;
    logic         core_done = 1'b0;
    logic         in_ready;
    logic         core_start;
    logic [W-1:0] core_a;
    logic [W-1:0] core_b;
    logic         busy;
    logic [$clog2(D):0] count;
    logic         timeout_err;

    gcd_operand_feeder #(.WIDTH(W), .DEPTH(D), .TIMEOUT(TO)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .core_start  (core_start),
        .core_a      (core_a),
        .core_b      (core_b),
        .core_done   (core_done),
        .busy        (busy),
        .count       (count),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        int           cyc;
    } pair_t;

    pair_t exp_q[$];
    pair_t cur;
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int pushes = 0;
    int starts = 0;
    int inflight = 0;
    int done_armed = 0;
    int done_cycle = -1;
    int to_cycle = -1;
    int end_cycle = -1;
    int prev_end = -100;
    int after_rst = 0;
    int mode = 0;          // 0: done after fixed_delay, 1: never done, 2: random delay
    int fixed_delay = 8;
    int noise_en = 0;
    int d;
    int exp_cnt;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s at cycle %0d", name, cyc);
    endtask

    // Reference: the core sees the pair as pushed, or max/min ordered when swapping is enabled.
    function automatic pair_t model(input logic [W-1:0] a, input logic [W-1:0] b, input int c);
        pair_t p;
        p.a = a;
        p.b = b;
        p.cyc = c;
`ifdef GCD_FEEDER_SWAP_EN
        if (a < b) begin
            p.a = b;
            p.b = a;
        end
`endif
        return p;
    endfunction

    // Core model: done pulse at the scheduled cycle, optional stray pulses while nothing is waiting.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            core_done = (done_armed != 0 && cyc == done_cycle) ||
                        (noise_en != 0 && inflight == 0 && !rst && $urandom_range(0, 3) == 0);
        end
    end

    // Monitor: every cycle compare the DUT against the scoreboard and the timing rules.
    always @(negedge clk) begin
        if (rst) begin
            chk("rst_in_ready", in_ready, 0);
            chk("rst_core_start", core_start, 0);
            chk("rst_timeout_err", timeout_err, 0);
            exp_q.delete();
            pushes = 0; starts = 0; inflight = 0; done_armed = 0;
            to_cycle = -1; end_cycle = -1; prev_end = -100; after_rst = 1;
        end else begin
            if (after_rst != 0) begin
                chk("post_rst_core_a", core_a, 0);
                chk("post_rst_core_b", core_b, 0);
                chk("post_rst_busy", busy, 0);
                after_rst = 0;
            end
            if (core_start) begin
                if (exp_q.size() == 0) begin
                    fail("spurious_core_start");
                end else begin
                    cur = exp_q.pop_front();
                    chk("start_core_a", core_a, cur.a);
                    chk("start_core_b", core_b, cur.b);
                    chk("start_cycle", cyc, (cur.cyc > prev_end) ? cur.cyc + 2 : prev_end + 2);
                    starts++;
                    inflight = 1;
                    case (mode)
                        0: d = fixed_delay;
                        1: d = TO + 100;
                        default: d = $urandom_range(1, TO + 6);
                    endcase
                    if (d <= TO) begin
                        done_cycle = cyc + d; done_armed = 1; to_cycle = -1; end_cycle = cyc + d;
                    end else begin
                        done_armed = 0; to_cycle = cyc + TO; end_cycle = cyc + TO;
                    end
                end
            end
            exp_cnt = pushes - starts;
            chk("count", count, exp_cnt);
            chk("in_ready", in_ready, exp_cnt != D);
            chk("busy", busy, inflight);
            chk("timeout_err", timeout_err, cyc == to_cycle);
            if (inflight != 0 && cyc == end_cycle) begin
                chk("hold_core_a", core_a, cur.a);
                chk("hold_core_b", core_b, cur.b);
                inflight = 0; done_armed = 0; prev_end = cyc; to_cycle = -1;
            end
            if (in_valid && exp_cnt != D) begin
                exp_q.push_back(model(in_a, in_b, cyc));
                pushes++;
            end
        end
    end

    task automatic push(input logic [W-1:0] a, input logic [W-1:0] b);
        int n = 0;
        logic ok;
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        forever begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            if (ok) break;
            n++;
            if (n > 200) begin
                fail("push_wait_budget");
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 || inflight != 0) begin
            @(posedge clk);
            #1;
            n++;
            if (n > 600) begin
                fail("drain_budget");
                break;
            end
        end
        idle(3);
    endtask

    initial begin
        idle(3);
        rst = 1'b0;
        idle(1);

        mode = 0; fixed_delay = 8;
        push(8'd48, 8'd18);
        drain();

        mode = 0; fixed_delay = 12;
        for (int i = 0; i < 6; i++) push(8'(20 + i), 8'(40 - i));
        drain();

        mode = 1;
        push(8'd9, 8'd6);
        push(8'd100, 8'd75);
        drain();

        mode = 0; fixed_delay = TO;
        push(8'd18, 8'd48);
        push(8'd7, 8'd7);
        drain();

        mode = 1;
        for (int i = 0; i < 4; i++) push(8'(60 + i), 8'(3 + i));
        idle(1);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        idle(20);

        mode = 0; fixed_delay = 3;
        for (int i = 0; i < 10; i++) push(8'(i * 7 + 1), 8'(i * 3 + 2));
        drain();

        mode = 2; noise_en = 1;
        for (int i = 0; i < 40; i++) begin
            idle($urandom_range(0, 2));
            push(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
        end
        drain();
        noise_en = 0;
        idle(2);

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
